// File: rtl/gmul_uni_seq.sv
// Sequential unipolar stochastic multiplier: latches two WIDTH-bit operands, streams
// their product over one 2^WIDTH-cycle epoch and reports the ones-count in binary.
module gmul_uni_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iStart,
    input  logic             iEn,
    input  logic             iClear,
    output logic             oReady,
    output logic             oValid,
    output logic             oC,
    output logic             oDone,
    output logic [WIDTH:0]   oCount
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] nRev;
    logic [WIDTH-1:0] aBuf;
    logic [WIDTH-1:0] bBuf;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   countReg;
    logic             lastStep;
    logic             streamBit;

    // A is compared against the bit-reversed counter so its stream is decorrelated from B's
    for (genvar g = 0; g < WIDTH; g++) begin : gRev
        assign nRev[g] = n[WIDTH-1-g];
    end

    always_comb begin
        streamBit = (aBuf > nRev) && (bBuf > n);
        lastStep  = (n == '1);
        oReady    = (state == IDLE);
        oDone     = (state == DONE);
        oValid    = (state == RUN) && iEn;
        oC        = (state == RUN) && iEn && streamBit;
        oCount    = countReg;
    end

    always_comb begin
        stateNext = state;
        if (iClear) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (iStart) stateNext = RUN;
                RUN:     if (iEn && lastStep) stateNext = DONE;
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n        <= '0;
            aBuf     <= '0;
            bBuf     <= '0;
            acc      <= '0;
            countReg <= '0;
        end else if (iClear) begin
            n   <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        aBuf <= iA;
                        bBuf <= iB;
                        n    <= '0;
                        acc  <= '0;
                    end
                end
                RUN: begin
                    if (iEn) begin
                        acc <= acc + (WIDTH+1)'(oC);
                        n   <= n + WIDTH'(1);
                        if (lastStep) begin
                            countReg <= acc + (WIDTH+1)'(oC);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gmul_uni_seq.sv
// Directed bench for gmul_uni_seq: a cycle model plus a queue of expected stream bits
// filled at each accepted start and drained on every valid output bit.
module tb_gmul_uni_seq;

    localparam int W = 8;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] iA;
    logic [W-1:0] iB;
    logic         iStart;
    logic         iEn;
    logic         iClear;
    logic         oReady;
    logic         oValid;
    logic         oC;
    logic         oDone;
    logic [W:0]   oCount;

    gmul_uni_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iA     (iA),
        .iB     (iB),
        .iStart (iStart),
        .iEn    (iEn),
        .iClear (iClear),
        .oReady (oReady),
        .oValid (oValid),
        .oC     (oC),
        .oDone  (oDone),
        .oCount (oCount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit sb[$];
    int mState = 0;      // 0 idle, 1 run, 2 done
    int mN     = 0;
    int mOnes  = 0;
    int mCount = 0;
    int cycNo  = 0;
    int acceptCyc = 0;
    int doneCyc   = 0;
    int doneCount = 0;
    int cHigh     = 0;
    int d0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int revf(input int x);
        int r = 0;
        int v = x;
        for (int i = 0; i < W; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic pushEpoch(input int a, input int b);
        sb.delete();
        for (int k = 0; k < N; k++) sb.push_back((a > revf(k)) && (b > k));
    endtask

    // one clock: drive inputs, check outputs against the model, then advance the model
    task automatic cyc(input logic st, input logic en, input logic clr);
        bit expBit;
        @(negedge clk);
        iStart = st;
        iEn    = en;
        iClear = clr;
        #1;
        cycNo++;
        chk("ready", oReady, (mState == 0));
        chk("done",  oDone,  (mState == 2));
        chk("valid", oValid, (mState == 1) && en);
        chk("count", oCount, mCount);
        if (oDone === 1'b1) begin
            doneCount++;
            doneCyc = cycNo;
        end
        if (oC === 1'b1) cHigh++;
        if (mState == 1 && en) begin
            if (sb.size() == 0) begin
                chk("sb_empty", oC, 1'bx);
            end else begin
                expBit = sb.pop_front();
                chk("bit", oC, expBit);
                mOnes += expBit;
            end
        end else begin
            chk("c_idle", oC, 1'b0);
        end
        if (clr) begin
            mState = 0;
            mN     = 0;
            mOnes  = 0;
            sb.delete();
        end else begin
            case (mState)
                0: if (st) begin
                    mState    = 1;
                    mN        = 0;
                    mOnes     = 0;
                    acceptCyc = cycNo;
                    pushEpoch(int'(iA), int'(iB));
                end
                1: if (en) begin
                    mN++;
                    if (mN == N) begin
                        mN     = 0;
                        mCount = mOnes;
                        mState = 2;
                    end
                end
                default: mState = 0;
            endcase
        end
    endtask

    task automatic runToDone(input bit stall, input int limit);
        int i = 0;
        while (mState == 1 && i < limit) begin
            cyc(1'b0, stall ? ((i % 2) == 0) : 1'b1, 1'b0);
            i++;
        end
        chk("timeout", mState, 2);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iA = '0; iB = '0; iStart = 1'b0; iEn = 1'b0; iClear = 1'b0;
        #3;
        chk("rst_ready", oReady, 1'b1);
        chk("rst_valid", oValid, 1'b0);
        chk("rst_c",     oC,     1'b0);
        chk("rst_done",  oDone,  1'b0);
        chk("rst_count", oCount, 0);
        #9 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // nominal epoch
        iA = 8'd100; iB = 8'd128;
        cyc(1'b1, 1'b1, 1'b0);
        runToDone(1'b0, 300);
        chk("nom_latency", doneCyc - acceptCyc, N + 1);
        chk("nom_count", oCount, 50);
        chk("nom_donecnt", doneCount, 1);
        cyc(1'b0, 1'b0, 1'b0);

        // zero operand
        iA = 8'd0; iB = 8'd200; cHigh = 0;
        cyc(1'b1, 1'b1, 1'b0);
        runToDone(1'b0, 300);
        chk("zero_count", oCount, 0);
        chk("zero_c_high", cHigh, 0);

        // full scale
        iA = 8'd255; iB = 8'd255;
        cyc(1'b1, 1'b1, 1'b0);
        runToDone(1'b0, 300);
        chk("full_count", oCount, 255);

        // abort at n = 40
        d0 = doneCount;
        iA = 8'd100; iB = 8'd128;
        cyc(1'b1, 1'b1, 1'b0);
        while (mN < 40 && mState == 1) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("abort_ready", oReady, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("abort_nodone", doneCount, d0);
        chk("abort_count", oCount, 255);

        // restart after abort, with stall pattern
        cyc(1'b1, 1'b1, 1'b0);
        runToDone(1'b1, 700);
        chk("stall_latency", doneCyc - acceptCyc, 2 * N);
        chk("stall_count", oCount, 50);

        // start and clear together in IDLE: clear wins
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("clr_start_ready", oReady, 1'b1);

        // back-to-back with iStart held high; operand change mid-run is ignored
        d0 = doneCount;
        iA = 8'd37; iB = 8'd201;
        for (int i = 0; i < 2 * (N + 2) + 4; i++) begin
            if (i == 100) begin iA = 8'd250; iB = 8'd3; end
            cyc(1'b1, 1'b1, 1'b0);
        end
        chk("b2b_donecnt", doneCount - d0, 2);
        chk("b2b_gap", acceptCyc - doneCyc, 1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-epoch clears everything including oCount
        iA = 8'd100; iB = 8'd128;
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("pre_rst_count", oCount, mCount);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", oReady, 1'b1);
        chk("mid_rst_valid", oValid, 1'b0);
        chk("mid_rst_c",     oC,     1'b0);
        chk("mid_rst_done",  oDone,  1'b0);
        chk("mid_rst_count", oCount, 0);
        mState = 0; mN = 0; mOnes = 0; mCount = 0; sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gmul_uni_seq.md
Name: gmul_uni_seq

Overview:
- Parametrised successor to the fixed-width unipolar stochastic multiplier.
- Accepts two WIDTH-bit unipolar operands through a ready/start handshake and runs one deterministic 2^WIDTH-cycle multiply epoch.
- During the epoch it emits the product bitstream, with a stall input and a synchronous abort.
- At the end it reports the accumulated ones-count as a binary result, so it sits between binary control logic and unary datapaths.

Parameters:
- WIDTH, 8: operand width; the epoch length is 2^WIDTH cycles; legal range 2..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- iA  in  WIDTH  operand A, unsigned; value = iA/2^WIDTH
- iB  in  WIDTH  operand B, unsigned; value = iB/2^WIDTH
- iStart  in  1  request to start an epoch; accepted when iStart & oReady
- iEn  in  1  advance enable during RUN; 0 = stall
- iClear  in  1  synchronous abort to IDLE
- oReady  out  1  high only in IDLE
- oValid  out  1  oC is a valid stream bit this cycle
- oC  out  1  product bitstream
- oDone  out  1  one-cycle pulse when the epoch completes
- oCount  out  WIDTH+1  number of 1s emitted in the last completed epoch

Behaviour:
- Reset: asynchronous on rst_n low. Values after reset:
  - state = IDLE, n = 0, A_buf = 0, B_buf = 0, acc = 0, oCount = 0.
  - oReady = 1, oValid = 0, oC = 0, oDone = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - oReady = 1.
  - On an edge with iStart = 1: A_buf <= iA, B_buf <= iB, n <= 0, acc <= 0, state <= RUN.
  - iStart while not in IDLE is ignored; there is no queueing.
- RUN:
  - oValid = iEn.
  - oC = iEn & (A_buf > rev(n)) & (B_buf > n), combinational from registered state.
  - rev(n) is the WIDTH-bit bit-reversal of n (van der Corput sequence). The two operand sequences are deliberately decorrelated.
  - On an edge with iEn = 1: acc <= acc + oC and n <= n + 1.
  - If n = 2^WIDTH - 1 on that edge: oCount <= acc + oC, n wraps to 0, state <= DONE.
  - iEn = 0: n and acc hold, oValid = 0, oC = 0.
- DONE:
  - Lasts exactly one cycle: oDone = 1, oValid = 0, oReady = 0.
  - Next edge goes to IDLE unconditionally.
  - oCount holds its value until the next epoch completes.
- Latency:
  - Accept edge, then 2^WIDTH enabled RUN cycles, then oDone.
  - With iEn held at 1, oDone is high in the cycle starting 2^WIDTH + 1 edges after the accept edge... precisely: accept at edge e0, final RUN edge is e(2^WIDTH), DONE is visible between e(2^WIDTH) and e(2^WIDTH + 1).
- Arithmetic:
  - acc is WIDTH+1 bits; the maximum count 2^WIDTH - 1 cannot overflow it.
  - Comparisons are strict and unsigned, so operand value 0 yields all-zero streams.
- iClear:
  - In any state it forces IDLE on the next edge.
  - acc and n are cleared; oCount is left unchanged; no oDone is generated.
  - iClear has priority over iStart and over epoch completion in the same cycle.
- Simultaneous iStart and iClear in IDLE: the clear wins and no epoch starts.
- Reset mid-epoch: everything returns to reset values immediately, including oCount = 0.

Test Plan:
- Reset check: WIDTH = 8, assert rst_n low mid-cycle -> oReady = 1, oValid = 0, oC = 0, oDone = 0, oCount = 0 asynchronously.
- Nominal epoch: iA = 100, iB = 128, iEn = 1 -> 256 valid bits; oDone pulse exactly one cycle; oCount = 50; oReady low from the accept edge until after DONE.
- Zero and full-scale operands:
  - iA = 0, iB = 200 -> oCount = 0 and oC never high.
  - iA = 255, iB = 255 -> oCount = 255.
- Stall: iA = 100, iB = 128, iEn toggled 1/0 every cycle -> oValid follows iEn; same bit sequence with gaps; oCount = 50; oDone 512 cycles after accept.
- Abort:
  - iClear at n = 40 during the iA = 100 / iB = 128 epoch -> IDLE next edge; no oDone; oCount keeps its previous value.
  - A new iStart is then accepted and completes normally.
- Back-to-back and ignored start: iStart held high continuously -> epochs restart only from IDLE, with exactly one DONE cycle and one IDLE cycle between epochs. An iStart pulse during RUN is ignored, and the operands latched for that epoch are unchanged.
